// File: rtl/bus_pkg.sv
// Shared constants and helpers for the registered CPU datapath bus (bus_mux_reg).
package bus_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;
  localparam int unsigned MAX_SRC   = 256;

  // Index width for a set of n sources; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic multi_hot(input logic [MAX_SRC-1:0] v);
    return (v & (v - MAX_SRC'(1))) != '0;
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational picker: first asserted request at or after i_start, wrapping at NUM_SRC-1.
module bus_arb_pick
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SRC = 24,
  parameter int unsigned IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic [IDX_W-1:0]   o_grant_c,
  output logic               o_any_req_c
);

  always_comb begin
    o_grant_c   = '0;
    o_any_req_c = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      int unsigned idx;
      idx = int'(i_start) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!o_any_req_c && i_req[IDX_W'(idx)]) begin
        o_grant_c   = IDX_W'(idx);
        o_any_req_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered datapath bus: one-hot source select with fixed/round-robin arbitration,
// stall and sticky contention detection. Define BUS_CONTENTION_CNT_EN for contention_cnt.
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_SRC  = 24,
  parameter int unsigned ARB_MODE = ARB_FIXED,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned IDX_W   = idx_w(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic                     stall,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [IDX_W-1:0]         bus_src,
  output logic                     contention
`ifdef BUS_CONTENTION_CNT_EN
  ,output logic [CNT_W-1:0]        contention_cnt
`endif
);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC || CNT_W < 1 || ARB_MODE > ARB_RR) begin : g_param_check
    $error("bus_mux_reg: illegal parameter combination");
  end

  logic [WIDTH-1:0] w_src_arr [NUM_SRC];
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_grant;
  logic [IDX_W-1:0] w_next_ptr;
  logic             w_any;
  logic             w_multi;

  logic [WIDTH-1:0] r_bus_out;
  logic             r_bus_valid;
  logic [IDX_W-1:0] r_bus_src;
  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_contention;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign w_src_arr[g] = src_data[g*WIDTH +: WIDTH];
  end

  // Fixed priority is round-robin pinned to a start index of zero.
  assign w_start    = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;
  assign w_multi    = multi_hot(MAX_SRC'(src_en));
  assign w_next_ptr = (w_grant == IDX_W'(NUM_SRC - 1)) ? '0 : w_grant + IDX_W'(1);

  bus_arb_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req       (src_en),
    .i_start     (w_start),
    .o_grant_c   (w_grant),
    .o_any_req_c (w_any)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_bus_out    <= '0;
      r_bus_valid  <= 1'b0;
      r_bus_src    <= '0;
      r_rr_ptr     <= '0;
      r_contention <= 1'b0;
    end else if (!stall) begin
      if (w_any) begin
        r_bus_out   <= w_src_arr[w_grant];
        r_bus_src   <= w_grant;
        r_bus_valid <= 1'b1;
        if (ARB_MODE == ARB_RR) r_rr_ptr <= w_next_ptr;
      end else begin
        r_bus_valid <= 1'b0;
      end
      // A new contention event outranks a simultaneous clear.
      if (w_multi)      r_contention <= 1'b1;
      else if (clr_err) r_contention <= 1'b0;
    end
  end

`ifdef BUS_CONTENTION_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (!stall) begin
      if (w_multi)      r_cnt <= clr_err ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
      else if (clr_err) r_cnt <= '0;
    end
  end

  assign contention_cnt = r_cnt;
`endif

  assign bus_out    = r_bus_out;
  assign bus_valid  = r_bus_valid;
  assign bus_src    = r_bus_src;
  assign contention = r_contention;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: fixed and round-robin instances share stimulus and are
// checked every cycle against a behavioural model plus directed literal checks.
module tb_bus_mux_reg;

  localparam int NS = 24;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            clr;
  logic [NS*W-1:0] src_data;
  logic [W-1:0]    data_arr [NS];
  logic [NS-1:0]   src_en;
  logic            stall;
  logic            clr_err;

  logic [W-1:0] fx_out, rr_out;
  logic         fx_valid, rr_valid;
  logic [4:0]   fx_src, rr_src;
  logic         fx_cont, rr_cont;
`ifdef BUS_CONTENTION_CNT_EN
  logic [1:0]   fx_cnt, rr_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NS; g++) begin : g_pack
    assign src_data[g*W +: W] = data_arr[g];
  end

  bus_mux_reg #(.WIDTH(W), .NUM_SRC(NS), .ARB_MODE(0), .CNT_W(2)) u_fix (
    .clk(clk), .clr(clr), .src_data(src_data), .src_en(src_en), .stall(stall),
    .clr_err(clr_err), .bus_out(fx_out), .bus_valid(fx_valid), .bus_src(fx_src),
    .contention(fx_cont)
`ifdef BUS_CONTENTION_CNT_EN
    ,.contention_cnt(fx_cnt)
`endif
  );

  bus_mux_reg #(.WIDTH(W), .NUM_SRC(NS), .ARB_MODE(1), .CNT_W(2)) u_rr (
    .clk(clk), .clr(clr), .src_data(src_data), .src_en(src_en), .stall(stall),
    .clr_err(clr_err), .bus_out(rr_out), .bus_valid(rr_valid), .bus_src(rr_src),
    .contention(rr_cont)
`ifdef BUS_CONTENTION_CNT_EN
    ,.contention_cnt(rr_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state, index 0 = fixed priority, 1 = round-robin.
  logic [W-1:0] m_out   [2];
  bit           m_valid [2];
  int           m_src   [2];
  bit           m_cont  [2];
  int           m_ptr   [2];
  int           m_cnt   [2];

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int m = 0; m < 2; m++) begin
        m_out[m] = '0; m_valid[m] = 0; m_src[m] = 0;
        m_cont[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0;
      end
    end else if (!stall) begin
      bit multi;
      multi = $countones(src_en) > 1;
      for (int m = 0; m < 2; m++) begin
        int win;
        int start;
        win   = -1;
        start = (m == 0) ? 0 : m_ptr[m];
        for (int k = 0; k < NS; k++)
          if (win < 0 && src_en[(start + k) % NS]) win = (start + k) % NS;
        if (win >= 0) begin
          m_out[m] = data_arr[win]; m_src[m] = win; m_valid[m] = 1;
          m_ptr[m] = (win + 1) % NS;
        end else begin
          m_valid[m] = 0;
        end
        if (multi) begin
          m_cont[m] = 1;
          m_cnt[m]  = clr_err ? 1 : ((m_cnt[m] + 1 > 3) ? 3 : m_cnt[m] + 1);
        end else if (clr_err) begin
          m_cont[m] = 0;
          m_cnt[m]  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("fx_out",   64'(fx_out),   64'(m_out[0]));
    check("fx_valid", 64'(fx_valid), 64'(m_valid[0]));
    check("fx_src",   64'(fx_src),   64'(m_src[0]));
    check("fx_cont",  64'(fx_cont),  64'(m_cont[0]));
    check("rr_out",   64'(rr_out),   64'(m_out[1]));
    check("rr_valid", 64'(rr_valid), 64'(m_valid[1]));
    check("rr_src",   64'(rr_src),   64'(m_src[1]));
    check("rr_cont",  64'(rr_cont),  64'(m_cont[1]));
`ifdef BUS_CONTENTION_CNT_EN
    check("fx_cnt",   64'(fx_cnt),   64'(m_cnt[0]));
    check("rr_cnt",   64'(rr_cnt),   64'(m_cnt[1]));
`endif
  end

  task automatic step(input logic [NS-1:0] en, input logic cerr, input logic stl);
    src_en  = en;
    clr_err = cerr;
    stall   = stl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int            rr_exp [4];
    logic [NS-1:0] st_en  [3];
    rr_exp = '{0, 7, 23, 0};
    st_en  = '{24'h000020, 24'h000140, 24'h000001};

    clr = 1'b1; src_en = '0; stall = 1'b0; clr_err = 1'b0;
    for (int i = 0; i < NS; i++) data_arr[i] = 32'h1000_0000 + 32'(i);
    data_arr[5] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check("rst_out",   64'(fx_out),   64'h0);
    check("rst_valid", 64'(fx_valid), 64'h0);
    check("rst_src",   64'(rr_src),   64'h0);
    check("rst_cont",  64'(rr_cont),  64'h0);
    clr = 1'b0;

    // Single source, then an idle edge.
    step(24'h000020, 1'b0, 1'b0);
    check("t2_out",   64'(fx_out),   64'hDEAD_BEEF);
    check("t2_src",   64'(fx_src),   64'd5);
    check("t2_valid", 64'(fx_valid), 64'd1);
    step(24'h0, 1'b0, 1'b0);
    check("t2_hold_out", 64'(fx_out),   64'hDEAD_BEEF);
    check("t2_idle_vld", 64'(fx_valid), 64'd0);
    check("t2_hold_src", 64'(fx_src),   64'd5);

    // Contention, clear, and clear-with-contention.
    step(24'h000208, 1'b0, 1'b0);
    check("t3_fx_src",  64'(fx_src),  64'd3);
    check("t3_cont",    64'(fx_cont), 64'd1);
    check("t3_rr_src",  64'(rr_src),  64'd9);
    step(24'h0, 1'b1, 1'b0);
    check("t3_clr",     64'(fx_cont), 64'd0);
    step(24'h000006, 1'b1, 1'b0);
    check("t3_set_wins", 64'(fx_cont), 64'd1);
    check("t3_rr_wrap",  64'(rr_src),  64'd1);
    step(24'h008000, 1'b0, 1'b0);
    check("t1_rr_pre",   64'(rr_src),  64'd15);

    // Async clear with a grant pending; rr_ptr would be 16 without it.
    data_arr[15] = 32'h5555_AAAA;
    src_en = 24'h008000;
    #2 clr = 1'b1;
    #1;
    check("t1_async_out",  64'(fx_out),   64'h0);
    check("t1_async_vld",  64'(rr_valid), 64'h0);
    check("t1_async_src",  64'(rr_src),   64'h0);
    check("t1_async_cont", 64'(fx_cont),  64'h0);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("t1_discard_out", 64'(rr_out),   64'h0);
    check("t1_discard_vld", 64'(rr_valid), 64'h0);

    // Round-robin wrap from a fresh pointer.
    for (int i = 0; i < 4; i++) begin
      step(24'h800081, 1'b0, 1'b0);
      check("t4_rr_src", 64'(rr_src), 64'(rr_exp[i]));
      check("t4_fx_src", 64'(fx_src), 64'd0);
    end

    // Stall freezes everything, including clr_err and the pointer.
    for (int i = 0; i < 3; i++) begin
      data_arr[0] = 32'hBAD0_0000 + 32'(i);
      step(st_en[i], 1'b1, 1'b1);
      check("t5_rr_src", 64'(rr_src),   64'd0);
      check("t5_rr_out", 64'(rr_out),   64'h1000_0000);
      check("t5_valid",  64'(rr_valid), 64'd1);
      check("t5_cont",   64'(fx_cont),  64'd1);
    end
    step(24'h001001, 1'b0, 1'b0);
    check("t5_rr_after", 64'(rr_src), 64'd12);
    check("t5_fx_out",   64'(fx_out), 64'hBAD0_0002);
    step(24'h0, 1'b1, 1'b0);
    check("t5_clr", 64'(rr_cont), 64'd0);

`ifdef BUS_CONTENTION_CNT_EN
    begin
      int cnt_exp [5];
      cnt_exp = '{1, 2, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
        step(24'h000006, 1'b0, 1'b0);
        check("t6_cnt", 64'(fx_cnt), 64'(cnt_exp[i]));
      end
      step(24'h000006, 1'b1, 1'b0);
      check("t6_clr_set", 64'(fx_cnt), 64'd1);
    end
`endif

    step(24'h0, 1'b0, 1'b0);
    step(24'h400000, 1'b0, 1'b0);
    check("end_src", 64'(fx_src), 64'd22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
